reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_CH, default 4: number of sequenced reset channels (1..16).
REQ-002 Parameter CNT_W, default 23: width of the sequencing counter.
REQ-003 Parameter FIRST, default 23'h1FFFFF: counter value that releases channel 0.
REQ-004 Parameter STEP, default 23'h100000: counter spacing between consecutive channel releases.
REQ-005 Parameter SHDN_GAP, default 16: clocks between channel drops during orderly shutdown (>=1).
REQ-006 Parameter SYNC_STAGES, default 2: synchroniser depth for iRST deassertion and iLOCK (>=2).
REQ-007 iCLK  input  1  single clock for all logic.
REQ-008 iRST  input  1  asynchronous, active-low reset; assertion acts immediately, deassertion synchronised internally.
REQ-009 iLOCK  input  1  clock-source lock indication, asynchronous, high = stable.
REQ-010 iSOFT  input  1  synchronous soft-reset request, sampled high on iCLK.
REQ-011 oRST  output  NUM_CH  per-channel active-low resets, 1 = channel released.
REQ-012 oDONE  output  1  high when all channels are released.
REQ-013 oBUSY  output  1  high while sequencing up or shutting down.

Function
REQ-014 Elaboration SHALL fail if FIRST+(NUM_CH-1)*STEP (= LAST) does not fit in CNT_W bits.
REQ-015 Internal reset SHALL assert asynchronously with iRST and deassert SYNC_STAGES iCLK edges after iRST rises.
REQ-016 iLOCK SHALL pass through a SYNC_STAGES flop chain (lock_s) before use; the chain clears under reset.
REQ-017 FSM states SHALL be IDLE, COUNT, DONE, SHUTDOWN; all outputs are registered.
REQ-018 IDLE: counter held at 0, oRST all 0; lock_s high -> COUNT on next edge.
REQ-019 COUNT: counter increments by 1 per clock, saturating at LAST; oRST[k] is set on the edge where counter >= FIRST+k*STEP and stays set.
REQ-020 COUNT with counter == LAST -> DONE on next edge; oRST[NUM_CH-1] and oDONE set on that same edge.
REQ-021 DONE: counter holds, oRST all 1, oDONE 1.
REQ-022 DONE with iSOFT high -> SHUTDOWN; oDONE cleared on that edge; oRST[NUM_CH-1] cleared on the same edge, then oRST[k-1] SHDN_GAP clocks after oRST[k] (highest index first).
REQ-023 SHUTDOWN: one edge after oRST[0] is cleared -> IDLE (restart if lock_s is high); iSOFT ignored in SHUTDOWN.
REQ-024 COUNT with iSOFT high -> next edge: oRST all 0, counter 0, state IDLE (abort, no ordered drop).
REQ-025 lock_s low in COUNT, DONE or SHUTDOWN -> next edge: oRST all 0, oDONE 0, counter 0, state IDLE; lock loss overrides iSOFT.
REQ-026 oBUSY SHALL be 1 exactly while state is COUNT or SHUTDOWN.
REQ-027 Counter SHALL never wrap: no increment past LAST in any state.

Reset
REQ-028 While iRST is low: oRST all 0, oDONE 0, oBUSY 0, counter 0, state IDLE, synchroniser flops 0.
REQ-029 iRST assertion mid-sequence or mid-shutdown SHALL clear all outputs without waiting for iCLK.
REQ-030 After iRST rises, no output SHALL change before the internal reset deasserts (REQ-015).

Verification (parameters NUM_CH=4, FIRST=10, STEP=5, SHDN_GAP=3, SYNC_STAGES=2)
REQ-031 iLOCK=1 held, iRST released -> COUNT entered; oRST[0..3] rise 11/16/21/26 clocks after COUNT entry; oDONE rises with oRST[3]; oBUSY high from COUNT entry until oDONE.
REQ-032 In DONE, 1-cycle iSOFT pulse -> oRST[3] drops on the next edge, then [2], [1], [0] at 3-clock spacing; oDONE low; IDLE one edge later, then full re-sequence as in REQ-031.
REQ-033 iLOCK dropped when oRST=4'b0011 -> within 2+1 clocks oRST=4'b0000, oBUSY=0; iLOCK restored -> sequence restarts from counter 0.
REQ-034 iSOFT high during COUNT with oRST=4'b0001 -> next edge oRST=4'b0000, state IDLE, immediate restart with iLOCK=1.
REQ-035 iRST pulsed low mid-SHUTDOWN between clock edges -> oRST, oDONE, oBUSY 0 asynchronously; release -> outputs stay 0 for 2 clocks, then normal sequence.
REQ-036 iLOCK low and iSOFT high on the same edge in DONE -> IDLE with all outputs 0 (lock loss wins, no SHUTDOWN).

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged release of NUM_CH active-low reset channels.
//
// After the input reset is released and the clock source reports lock, a
// saturating counter runs. Each channel k is released once the counter
// reaches FIRST + k*STEP. Once all channels are released the block sits in
// DONE. A soft request from DONE drops the channels in reverse order,
// SHDN_GAP clocks apart. A soft request while counting aborts immediately.
// Loss of lock drops everything at once.
//
// Ports:
//   iCLK   in   single clock for all logic
//   iRST   in   asynchronous active-low reset (release synchronised inside)
//   iLOCK  in   asynchronous clock-source lock indication, high = stable
//   iSOFT  in   synchronous soft-reset request
//   oRST   out  per-channel active-low resets, 1 = channel released
//   oDONE  out  all channels released
//   oBUSY  out  sequencing up or shutting down
module reset_sequencer #(
  parameter int              NUM_CH      = 4,
  parameter int              CNT_W       = 23,
  parameter longint unsigned FIRST       = 23'h1FFFFF,
  parameter longint unsigned STEP        = 23'h100000,
  parameter int              SHDN_GAP    = 16,
  parameter int              SYNC_STAGES = 2
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iLOCK,
  input  logic              iSOFT,
  output logic [NUM_CH-1:0] oRST,
  output logic              oDONE,
  output logic              oBUSY
);

  localparam longint unsigned LAST  = FIRST + STEP * longint'(NUM_CH - 1);
  localparam int              IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int              GAP_W = $clog2(SHDN_GAP + 1);
  localparam logic [CNT_W-1:0] LAST_C = LAST[CNT_W-1:0];

  if (LAST >= (64'd1 << CNT_W)) begin : g_last_chk
    $error("reset_sequencer: FIRST+(NUM_CH-1)*STEP does not fit in CNT_W bits");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_ch_chk
    $error("reset_sequencer: NUM_CH must be 1..16");
  end
  if (SYNC_STAGES < 2) begin : g_sync_chk
    $error("reset_sequencer: SYNC_STAGES must be >= 2");
  end
  if (SHDN_GAP < 1) begin : g_gap_chk
    $error("reset_sequencer: SHDN_GAP must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, COUNT, DONE, SHUTDOWN} state_t;

  function automatic logic [CNT_W-1:0] thr(input int k);
    longint unsigned t;
    t = FIRST + STEP * longint'(k);
    return t[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= LAST_C) ? v : v + 1'b1;
  endfunction

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   rst_n_int;
  logic                   lock_s;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_CH-1:0]  orst_q;
  logic               done_q;
  logic               busy_q;
  logic [IDX_W-1:0]   idx_q;
  logic [GAP_W-1:0]   gap_q;
  logic [NUM_CH-1:0]  rel_d;

  // Reset bridge: asserts with iRST, releases SYNC_STAGES edges after it rises.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) rst_sync_q <= '0;
    else       rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[SYNC_STAGES-1];

  always_ff @(posedge iCLK or negedge rst_n_int) begin
    if (!rst_n_int) lock_sync_q <= '0;
    else            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], iLOCK};
  end
  assign lock_s = lock_sync_q[SYNC_STAGES-1];

  // Channels whose release threshold the current count has reached.
  always_comb begin
    rel_d = '0;
    for (int k = 0; k < NUM_CH; k++) rel_d[k] = (cnt_q >= thr(k));
  end

  always_ff @(posedge iCLK or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      orst_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      idx_q   <= '0;
      gap_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          orst_q <= '0;
          done_q <= 1'b0;
          if (lock_s) begin
            state_q <= COUNT;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        COUNT: begin
          // Lock loss and soft abort both drop all channels at once.
          if (!lock_s || iSOFT) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            orst_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q  <= sat_inc(cnt_q);
            orst_q <= orst_q | rel_d;
            if (cnt_q == LAST_C) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        DONE: begin
          if (!lock_s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            orst_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (iSOFT) begin
            state_q            <= SHUTDOWN;
            orst_q[NUM_CH-1]   <= 1'b0;
            done_q             <= 1'b0;
            busy_q             <= 1'b1;
            idx_q              <= IDX_W'(NUM_CH - 1);
            gap_q              <= '0;
          end
        end
        SHUTDOWN: begin
          if (!lock_s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            orst_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (idx_q == '0) begin
            // Channel 0 went down on the previous edge.
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (gap_q == GAP_W'(SHDN_GAP - 1)) begin
            orst_q[idx_q - 1'b1] <= 1'b0;
            idx_q                <= idx_q - 1'b1;
            gap_q                <= '0;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          orst_q  <= '0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign oRST  = orst_q;
  assign oDONE = done_q;
  assign oBUSY = busy_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with NUM_CH=4, FIRST=10, STEP=5,
// SHDN_GAP=3, SYNC_STAGES=2. Inputs change on the falling edge; outputs are
// sampled 1 time unit after the rising edge.
module tb_reset_sequencer;

  logic       iCLK = 1'b0;
  logic       iRST;
  logic       iLOCK;
  logic       iSOFT;
  logic [3:0] oRST;
  logic       oDONE;
  logic       oBUSY;

  int checks = 0;
  int errors = 0;

  always #5 iCLK = ~iCLK;

  reset_sequencer #(
    .NUM_CH(4), .CNT_W(23), .FIRST(10), .STEP(5),
    .SHDN_GAP(3), .SYNC_STAGES(2)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iLOCK(iLOCK), .iSOFT(iSOFT),
    .oRST(oRST), .oDONE(oDONE), .oBUSY(oBUSY)
  );

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic to_neg();
    @(negedge iCLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ticks until oBUSY is seen high; n = number of ticks, -1 if never.
  task automatic wait_busy(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (oBUSY === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Called right after the edge that entered COUNT (counter = 0).
  task automatic check_seq(input string tag);
    int rise[4];
    int drise;
    int busy_bad;
    drise    = 0;
    busy_bad = 0;
    for (int k = 0; k < 4; k++) rise[k] = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      for (int k = 0; k < 4; k++)
        if (oRST[k] === 1'b1 && rise[k] == 0) rise[k] = i;
      if (oDONE === 1'b1 && drise == 0) drise = i;
      if (oDONE !== 1'b1 && oBUSY !== 1'b1) busy_bad++;
    end
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s_rise%0d", tag, k), rise[k], 11 + 5 * k);
    chk({tag, "_done_rise"}, drise, 26);
    chk({tag, "_busy_while_counting"}, busy_bad, 0);
    chk({tag, "_final_rst"}, {28'd0, oRST}, 32'hF);
    chk({tag, "_final_done"}, {31'd0, oDONE}, 1);
    chk({tag, "_final_busy"}, {31'd0, oBUSY}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    iRST  = 1'b0;
    iLOCK = 1'b1;
    iSOFT = 1'b0;
    repeat (3) tick();
    chk("reset_rst",  {28'd0, oRST}, 0);
    chk("reset_done", {31'd0, oDONE}, 0);
    chk("reset_busy", {31'd0, oBUSY}, 0);

    // Release reset: two held edges, two lock-sync edges, then COUNT.
    to_neg(); iRST = 1'b1;
    tick();
    chk("hold1_rst",  {28'd0, oRST}, 0);
    chk("hold1_busy", {31'd0, oBUSY}, 0);
    tick();
    chk("hold2_rst",  {28'd0, oRST}, 0);
    chk("hold2_busy", {31'd0, oBUSY}, 0);
    wait_busy(10, n);
    chk("entry_after_rst", n, 3);
    chk("entry_rst", {28'd0, oRST}, 0);
    check_seq("seq1");

    // Orderly shutdown; iSOFT held over one extra edge is ignored.
    to_neg(); iSOFT = 1'b1;
    tick();
    chk("shd0_rst",  {28'd0, oRST}, 4'b0111);
    chk("shd0_done", {31'd0, oDONE}, 0);
    chk("shd0_busy", {31'd0, oBUSY}, 1);
    tick();
    to_neg(); iSOFT = 1'b0;
    tick();
    chk("shd2_rst", {28'd0, oRST}, 4'b0111);
    tick();
    chk("shd3_rst", {28'd0, oRST}, 4'b0011);
    repeat (2) tick();
    chk("shd5_rst", {28'd0, oRST}, 4'b0011);
    tick();
    chk("shd6_rst", {28'd0, oRST}, 4'b0001);
    repeat (3) tick();
    chk("shd9_rst",  {28'd0, oRST}, 4'b0000);
    chk("shd9_busy", {31'd0, oBUSY}, 1);
    tick();
    chk("shd10_busy", {31'd0, oBUSY}, 0);
    tick();
    chk("shd11_busy", {31'd0, oBUSY}, 1);
    check_seq("seq2");

    // Lock loss and soft request coincide in DONE: lock loss wins.
    to_neg(); iLOCK = 1'b0;
    repeat (2) tick();
    chk("pre_lockloss_done", {31'd0, oDONE}, 1);
    to_neg(); iSOFT = 1'b1;
    tick();
    chk("lockwin_rst",  {28'd0, oRST}, 0);
    chk("lockwin_done", {31'd0, oDONE}, 0);
    chk("lockwin_busy", {31'd0, oBUSY}, 0);
    to_neg(); iSOFT = 1'b0;
    repeat (3) tick();
    chk("nolock_busy", {31'd0, oBUSY}, 0);
    chk("nolock_rst",  {28'd0, oRST}, 0);

    // Lock loss mid-count at oRST = 0011.
    to_neg(); iLOCK = 1'b1;
    wait_busy(10, n);
    chk("entry_after_lock", n, 3);
    repeat (16) tick();
    chk("mid_rst", {28'd0, oRST}, 4'b0011);
    to_neg(); iLOCK = 1'b0;
    repeat (3) tick();
    chk("lockloss_rst",  {28'd0, oRST}, 0);
    chk("lockloss_busy", {31'd0, oBUSY}, 0);

    // Restart from counter 0, then soft abort at oRST = 0001.
    to_neg(); iLOCK = 1'b1;
    wait_busy(10, n);
    chk("entry_relock", n, 3);
    repeat (10) tick();
    chk("restart10_rst", {28'd0, oRST}, 4'b0000);
    tick();
    chk("restart11_rst", {28'd0, oRST}, 4'b0001);
    to_neg(); iSOFT = 1'b1;
    tick();
    chk("abort_rst",  {28'd0, oRST}, 0);
    chk("abort_busy", {31'd0, oBUSY}, 0);
    to_neg(); iSOFT = 1'b0;
    tick();
    chk("abort_restart_busy", {31'd0, oBUSY}, 1);
    check_seq("seq3");

    // Asynchronous reset in the middle of a shutdown.
    to_neg(); iSOFT = 1'b1;
    tick();
    to_neg(); iSOFT = 1'b0;
    repeat (3) tick();
    chk("pre_arst_rst",  {28'd0, oRST}, 4'b0011);
    chk("pre_arst_busy", {31'd0, oBUSY}, 1);
    #2;
    iRST = 1'b0;
    #1;
    chk("arst_rst",  {28'd0, oRST}, 0);
    chk("arst_done", {31'd0, oDONE}, 0);
    chk("arst_busy", {31'd0, oBUSY}, 0);
    to_neg(); iRST = 1'b1;
    tick();
    chk("arst_hold1_rst",  {28'd0, oRST}, 0);
    chk("arst_hold1_busy", {31'd0, oBUSY}, 0);
    tick();
    chk("arst_hold2_rst",  {28'd0, oRST}, 0);
    chk("arst_hold2_busy", {31'd0, oBUSY}, 0);
    wait_busy(10, n);
    chk("entry_after_arst", n, 3);
    check_seq("seq4");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
